adr_seq_ctrl: RTL
=================

# adr_seq_ctrl

ADR (Asynchronous DRAM Refresh) sequencer for the core CPLD. It consumes the latched ADR mode and filtered ADR_COMPLETE from the ADR latch, and qualifies the PSU power-fail warning. It then drives ADR_TRIGGER to the PCH, times the PCH response, and generates the ADR ACK pulse fed back into the ADR latch. A sticky timeout flag and the state code are exported for the BMC/SMBus register file.

## Interface
- DEBOUNCE, 4: consecutive low samples of iPwrFail_n needed to trigger ADR (legal 2..255; 2 µs at 2 MHz).
- TIMEOUT, 2000: maximum cycles in TRIGGER waiting for ADR_COMPLETE (legal 2..65535; 1 ms at 2 MHz).
- ACK_WIDTH, 4: cycles oAdrAck is held high (legal 1..255).

- iClk  in  1  2 MHz system clock; only clock in the block.
- iRst_n  in  1  reset, asynchronous, active-low.
- iAdrMode0  in  1  latched ADR_MODE0.
- iAdrMode1  in  1  latched ADR_MODE1; {iAdrMode1,iAdrMode0}==2'b00 means ADR disabled.
- iAdrComplete  in  1  filtered ADR_COMPLETE from the PCH, active-high.
- iArm  in  1  BIOS latch point reached (ADR_COMPLETE filter enabled), active-high.
- iSlpS5_n  in  1  PCH SLP_S5#, active-low.
- iPwrFail_n  in  1  PSU power-fail warning, already synchronized, active-low.
- oAdrTrigger_n  out  1  ADR_TRIGGER# to the PCH, active-low.
- oAdrAck  out  1  ADR ACK to the ADR latch, active-high.
- oAdrActive  out  1  high in TRIGGER, ACK and DONE.
- oAdrTimeout  out  1  sticky flag: PCH failed to complete ADR within TIMEOUT.
- oState  out  3  current state encoding.

## Operation
- States and oState codes: IDLE=0, ARMED=1, QUAL=2, TRIGGER=3, ACK=4, DONE=5, FAULT=6. Code 7 is unreachable and recovers to IDLE.
- Global rule, highest priority: iSlpS5_n low in any state moves to IDLE next edge and clears the counters. oAdrTimeout is not cleared by this.
- IDLE: go to ARMED when iArm=1, iSlpS5_n=1 and mode!=00.
- ARMED: go to IDLE if iArm=0 or mode==00. Otherwise, iPwrFail_n=0 moves to QUAL with cnt=1.
- QUAL: iPwrFail_n=1 returns to ARMED. If iPwrFail_n=0 and cnt==DEBOUNCE-1, go to TRIGGER with timer=0. Otherwise cnt+1. iArm and mode are not checked here.
- TRIGGER: iAdrComplete=1 moves to ACK with cnt=0. Otherwise, if timer==TIMEOUT-1, go to FAULT. Otherwise timer+1. Complete wins over timeout on the same edge.
- ADR is committed once TRIGGER is entered: iArm, mode and iPwrFail_n are ignored from TRIGGER through DONE.
- ACK: when cnt==ACK_WIDTH-1, go to DONE; else cnt+1.
- DONE: hold until iSlpS5_n=0.
- FAULT: set oAdrTimeout=1 and hold until iSlpS5_n=0. oAdrTimeout is cleared only by iRst_n.
- Output decode:
  - oAdrTrigger_n=0 in TRIGGER, ACK and DONE; 1 elsewhere. FAULT releases the trigger.
  - oAdrAck=1 only in ACK.
- Counter widths: cnt is 8 bits and timer is 16 bits. Neither wraps; both are reloaded on every state entry.

## Timing
- Reset values: state=IDLE, oAdrTrigger_n=1, oAdrAck=0, oAdrActive=0, oAdrTimeout=0, oState=0, counters=0.
- All outputs are registered and update on the same edge as the state change; there is no combinational path from inputs to outputs.
- Power-fail latency: if iPwrFail_n is first sampled low in ARMED at edge k, oAdrTrigger_n falls at edge k+DEBOUNCE-1. This requires DEBOUNCE consecutive low samples.
- Complete latency: iAdrComplete sampled high at edge m gives oAdrAck high from edge m through edge m+ACK_WIDTH-1. It falls at edge m+ACK_WIDTH.
- Timeout: with no complete, FAULT is entered exactly TIMEOUT edges after TRIGGER entry.
- Reset mid-operation: asserting iRst_n releases oAdrTrigger_n immediately (asynchronously), with no wait for a clock edge.

## Test plan
- Normal flow (mode=01, iArm=1, iSlpS5_n=1): drop iPwrFail_n, then raise iAdrComplete 10 cycles after trigger. Expect the trigger 3 edges after the first low sample, oAdrAck high for 4 cycles, state DONE=5, and the trigger held low.
- Glitch: iPwrFail_n low for 3 cycles then high. Expect QUAL→ARMED, oAdrTrigger_n never low, and oState back to 1.
- Timeout: trigger with iAdrComplete held low. Expect FAULT=6 exactly 2000 edges after TRIGGER entry, oAdrTimeout=1, and oAdrTrigger_n=1. Then pulse iSlpS5_n low. Expect IDLE with oAdrTimeout still 1.
- Simultaneous events: iAdrComplete rises on the edge where timer==TIMEOUT-1. Expect ACK, not FAULT, and oAdrTimeout=0.
- Disable/priority: with mode=00, iPwrFail_n low produces no trigger. During ACK, iSlpS5_n low gives IDLE next edge with oAdrAck=0.
- Async reset during TRIGGER: oAdrTrigger_n goes to 1 before the next iClk edge, and all outputs return to their reset values.

Source files
------------

// File: rtl/adr_seq_ctrl.sv
// ADR sequencer: qualifies PSU power-fail, drives ADR_TRIGGER# to the PCH,
// times the PCH response, generates ADR ACK and keeps a sticky timeout flag.
// Ports: iClk/iRst_n (async low reset), iAdrMode0/1, iAdrComplete, iArm,
//   iSlpS5_n, iPwrFail_n in; oAdrTrigger_n, oAdrAck, oAdrActive,
//   oAdrTimeout, oState[2:0] out (all registered).
module adr_seq_ctrl #(
    parameter int DEBOUNCE  = 4,
    parameter int TIMEOUT   = 2000,
    parameter int ACK_WIDTH = 4
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iAdrMode0,
    input  logic       iAdrMode1,
    input  logic       iAdrComplete,
    input  logic       iArm,
    input  logic       iSlpS5_n,
    input  logic       iPwrFail_n,
    output logic       oAdrTrigger_n,
    output logic       oAdrAck,
    output logic       oAdrActive,
    output logic       oAdrTimeout,
    output logic [2:0] oState
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_QUAL    = 3'd2;
    localparam logic [2:0] S_TRIGGER = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_FAULT   = 3'd6;

    localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [7:0]  ACK_LAST = 8'(ACK_WIDTH - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] timer_q, timer_d;
    logic        trig_n_q, trig_n_d;
    logic        ack_q, ack_d;
    logic        active_q, active_d;
    logic        timeout_q, timeout_d;
    logic        mode_en;

    assign mode_en = iAdrMode1 | iAdrMode0;

    // State and registered outputs
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            timer_q   <= '0;
            trig_n_q  <= 1'b1;
            ack_q     <= 1'b0;
            active_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            trig_n_q  <= trig_n_d;
            ack_q     <= ack_d;
            active_q  <= active_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state and counters; counters reload on each state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        if (!iSlpS5_n) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            timer_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (iArm && mode_en) begin
                        state_d = S_ARMED;
                        cnt_d   = '0;
                    end
                end
                S_ARMED: begin
                    if (!iArm || !mode_en) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (!iPwrFail_n) begin
                        state_d = S_QUAL;
                        cnt_d   = 8'd1;
                    end
                end
                S_QUAL: begin
                    if (iPwrFail_n) begin
                        state_d = S_ARMED;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = S_TRIGGER;
                        cnt_d   = '0;
                        timer_d = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_TRIGGER: begin
                    // Complete takes precedence over an expiring timer
                    if (iAdrComplete) begin
                        state_d = S_ACK;
                        cnt_d   = '0;
                        timer_d = '0;
                    end else if (timer_q == TO_LAST) begin
                        state_d = S_FAULT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                S_ACK: begin
                    if (cnt_q == ACK_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_DONE:  state_d = S_DONE;
                S_FAULT: state_d = S_FAULT;
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they change with it
    always_comb begin
        trig_n_d  = 1'b1;
        ack_d     = 1'b0;
        active_d  = 1'b0;
        timeout_d = timeout_q | (state_d == S_FAULT);
        unique case (state_d)
            S_TRIGGER, S_DONE: begin
                trig_n_d = 1'b0;
                active_d = 1'b1;
            end
            S_ACK: begin
                trig_n_d = 1'b0;
                active_d = 1'b1;
                ack_d    = 1'b1;
            end
            default: ;
        endcase
    end

    assign oAdrTrigger_n = trig_n_q;
    assign oAdrAck       = ack_q;
    assign oAdrActive    = active_q;
    assign oAdrTimeout   = timeout_q;
    assign oState        = state_q;

endmodule
